// File: rtl/matrix_mult_engine.sv
// Sequencing datapath computing C = A x B from two async-read operand memories
// into a sync-write result memory, one MAC per cycle, one C element per INNER+1 cycles.
module matrix_mult_engine #(
   parameter int unsigned ROW      = 2,
   parameter int unsigned INNER    = 2,
   parameter int unsigned COL      = 2,
   parameter int unsigned SIZE     = 8,
   parameter int unsigned OUT_SIZE = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                a_read,
   output logic [5:0]          a_read_address,
   input  logic [SIZE-1:0]     a_data,
   output logic                b_read,
   output logic [5:0]          b_read_address,
   input  logic [SIZE-1:0]     b_data,
   output logic                c_write,
   output logic [5:0]          c_write_address,
   output logic [OUT_SIZE-1:0] c_write_value
);

   localparam int unsigned AW = 6;
   localparam int unsigned PW = 2 * SIZE;
   localparam int unsigned IW = (ROW   > 1) ? $clog2(ROW)   : 1;
   localparam int unsigned KW = (INNER > 1) ? $clog2(INNER) : 1;
   localparam int unsigned JW = (COL   > 1) ? $clog2(COL)   : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state, state_d;
   logic [IW-1:0]       i, i_d;
   logic [KW-1:0]       k, k_d;
   logic [JW-1:0]       j, j_d;
   logic [OUT_SIZE-1:0] acc, acc_d;
   logic [PW-1:0]       product_c;
   logic [OUT_SIZE-1:0] product_ext_c;
   logic [AW-1:0]       a_addr_c, b_addr_c, c_addr_c;

   // Full-width product, then fit (zero-extend or truncate) to accumulator width
   always_comb begin
      product_c     = PW'(a_data) * PW'(b_data);
      product_ext_c = OUT_SIZE'(product_c);
   end

   // Next-state, counter and accumulator logic
   always_comb begin
      state_d = state;
      i_d     = i;
      j_d     = j;
      k_d     = k;
      acc_d   = acc;
      case (state)
         IDLE: begin
            if (start) begin
               state_d = MAC;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
            end
         end
         MAC: begin
            acc_d = ((k == '0) ? '0 : acc) + product_ext_c;
            if (k == KW'(INNER - 1)) state_d = WRITE;
            else                     k_d     = k + 1'b1;
         end
         WRITE: begin
            k_d = '0;
            if (j == JW'(COL - 1)) begin
               j_d = '0;
               if (i == IW'(ROW - 1)) begin
                  i_d     = '0;
                  state_d = DONE;
               end else begin
                  i_d     = i + 1'b1;
                  state_d = MAC;
               end
            end else begin
               j_d     = j + 1'b1;
               state_d = MAC;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Row-major addresses of the element touched in the next cycle
   always_comb begin
      a_addr_c = AW'(32'(i_d) * INNER + 32'(k_d));
      b_addr_c = AW'(32'(k_d) * COL + 32'(j_d));
      c_addr_c = AW'(32'(i_d) * COL + 32'(j_d));
   end

   // Outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         i               <= '0;
         j               <= '0;
         k               <= '0;
         acc             <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         a_read          <= 1'b0;
         b_read          <= 1'b0;
         a_read_address  <= '0;
         b_read_address  <= '0;
         c_write         <= 1'b0;
         c_write_address <= '0;
         c_write_value   <= '0;
      end else begin
         state           <= state_d;
         i               <= i_d;
         j               <= j_d;
         k               <= k_d;
         acc             <= acc_d;
         busy            <= (state_d == MAC) || (state_d == WRITE);
         done            <= (state_d == DONE);
         a_read          <= (state_d == MAC);
         b_read          <= (state_d == MAC);
         a_read_address  <= (state_d == MAC) ? a_addr_c : '0;
         b_read_address  <= (state_d == MAC) ? b_addr_c : '0;
         c_write         <= (state_d == WRITE);
         c_write_address <= (state_d == WRITE) ? c_addr_c : '0;
         c_write_value   <= (state_d == WRITE) ? acc_d : '0;
      end
   end

endmodule

// File: tb/tb_matrix_mult_engine.sv
// Directed bench for matrix_mult_engine: a default 2x2x2 instance and a 2x3x1 instance,
// each with behavioural A/B/C memories; expected values are hand-computed.
module tb_matrix_mult_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- default 2x2x2 instance ----------------
   logic        rst0, start0, busy0, done0, a_read0, b_read0, c_write0;
   logic [5:0]  a_addr0, b_addr0, c_addr0;
   logic [7:0]  a_data0, b_data0;
   logic [15:0] c_val0;
   logic [7:0]  a_mem0 [64];
   logic [7:0]  b_mem0 [64];
   logic [15:0] c_mem0 [64];
   logic        clr_c;

   assign a_data0 = a_mem0[a_addr0];
   assign b_data0 = b_mem0[b_addr0];

   always @(posedge clk) begin
      if (clr_c) begin
         for (int n = 0; n < 64; n++) c_mem0[n] <= 16'hDEAD;
      end else if (c_write0) begin
         c_mem0[c_addr0] <= c_val0;
      end
   end

   matrix_mult_engine dut0 (
      .clk(clk), .rst(rst0), .start(start0), .busy(busy0), .done(done0),
      .a_read(a_read0), .a_read_address(a_addr0), .a_data(a_data0),
      .b_read(b_read0), .b_read_address(b_addr0), .b_data(b_data0),
      .c_write(c_write0), .c_write_address(c_addr0), .c_write_value(c_val0)
   );

   // ---------------- 2x3x1 instance ----------------
   logic        rst1, start1, busy1, done1, a_read1, b_read1, c_write1;
   logic [5:0]  a_addr1, b_addr1, c_addr1;
   logic [7:0]  a_data1, b_data1;
   logic [15:0] c_val1;
   logic [7:0]  a_mem1 [64];
   logic [7:0]  b_mem1 [64];

   assign a_data1 = a_mem1[a_addr1];
   assign b_data1 = b_mem1[b_addr1];

   matrix_mult_engine #(.ROW(2), .INNER(3), .COL(1), .SIZE(8), .OUT_SIZE(16)) dut1 (
      .clk(clk), .rst(rst1), .start(start1), .busy(busy1), .done(done1),
      .a_read(a_read1), .a_read_address(a_addr1), .a_data(a_data1),
      .b_read(b_read1), .b_read_address(b_addr1), .b_data(b_data1),
      .c_write(c_write1), .c_write_address(c_addr1), .c_write_value(c_val1)
   );

   task automatic load_basic();
      for (int n = 0; n < 64; n++) begin
         a_mem0[n] = 8'd0;
         b_mem0[n] = 8'd0;
      end
      a_mem0[0] = 8'd1; a_mem0[1] = 8'd2; a_mem0[2] = 8'd3; a_mem0[3] = 8'd4;
      b_mem0[0] = 8'd5; b_mem0[1] = 8'd6; b_mem0[2] = 8'd7; b_mem0[3] = 8'd8;
   endtask

   // One full 2x2x2 run; cycle 0 is the cycle start is high in IDLE.
   task automatic run2x2(input string tag, input int e0, input int e1, input int e2,
                         input int e3, input bit hold);
      int exp_c [4];
      int nw;
      int done_at;
      exp_c[0] = e0; exp_c[1] = e1; exp_c[2] = e2; exp_c[3] = e3;
      nw = 0;
      done_at = -1;
      @(negedge clk);
      check({tag, "_idle_busy"}, int'(busy0), 0);
      start0 = 1'b1;
      for (int t = 1; t <= 13; t++) begin
         @(negedge clk);
         if (!hold) start0 = 1'b0;
         if (t == 1) begin
            check({tag, "_busy1"}, int'(busy0), 1);
            check({tag, "_aread1"}, int'(a_read0), 1);
         end
         if (t == 2) begin
            check({tag, "_aaddr2"}, int'(a_addr0), 1);
            check({tag, "_baddr2"}, int'(b_addr0), 2);
         end
         if (t == 3) begin
            check({tag, "_aread3"}, int'(a_read0), 0);
            check({tag, "_aaddr3"}, int'(a_addr0), 0);
         end
         if (c_write0) begin
            if (nw < 4) begin
               check({tag, "_wcyc"}, t, (nw + 1) * 3);
               check({tag, "_waddr"}, int'(c_addr0), nw);
               check({tag, "_wval"}, int'(c_val0), exp_c[nw]);
            end
            nw++;
         end else begin
            if (c_val0 !== 16'd0 || c_addr0 !== 6'd0) check({tag, "_wzero"}, int'(c_val0), 0);
         end
         if (done0 && done_at < 0) done_at = t;
      end
      check({tag, "_nwrites"}, nw, 4);
      check({tag, "_done_cyc"}, done_at, 13);
      check({tag, "_done_busy"}, int'(busy0), 0);
   endtask

   initial begin
      int bseq [6];
      int nb;
      int nw;
      int done_at;

      rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0; clr_c = 1'b1;
      load_basic();
      for (int n = 0; n < 64; n++) begin
         a_mem1[n] = 8'd0;
         b_mem1[n] = 8'd0;
      end
      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy0), 0);
      check("rst_done", int'(done0), 0);
      check("rst_aread", int'(a_read0), 0);
      check("rst_bread", int'(b_read0), 0);
      check("rst_cwrite", int'(c_write0), 0);
      check("rst_addrs", int'(a_addr0) + int'(b_addr0) + int'(c_addr0), 0);
      check("rst_cval", int'(c_val0), 0);
      rst0 = 1'b0; rst1 = 1'b0; clr_c = 1'b0;

      run2x2("basic", 19, 22, 43, 50, 1'b0);

      for (int n = 0; n < 4; n++) begin
         a_mem0[n] = 8'd255;
         b_mem0[n] = 8'd255;
      end
      run2x2("ovf", 64514, 64514, 64514, 64514, 1'b0);

      load_basic();
      run2x2("hold1", 19, 22, 43, 50, 1'b1);
      run2x2("hold2", 19, 22, 43, 50, 1'b1);
      start0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("hold_end_busy", int'(busy0), 0);

      // Reset during the second element's MAC
      clr_c = 1'b1;
      @(negedge clk);
      clr_c = 1'b0;
      start0 = 1'b1;
      for (int t = 1; t <= 4; t++) begin
         @(negedge clk);
         start0 = 1'b0;
         if (t == 4) rst0 = 1'b1;
      end
      @(negedge clk);
      rst0 = 1'b0;
      check("midrst_busy", int'(busy0), 0);
      check("midrst_strobes", int'(a_read0) + int'(b_read0) + int'(c_write0) + int'(done0), 0);
      repeat (3) @(negedge clk);
      check("midrst_busy_later", int'(busy0), 0);
      check("midrst_c0", int'(c_mem0[0]), 19);
      check("midrst_c1", int'(c_mem0[1]), 16'hDEAD);
      check("midrst_c3", int'(c_mem0[3]), 16'hDEAD);
      run2x2("post_rst", 19, 22, 43, 50, 1'b0);
      check("post_rst_c3", int'(c_mem0[3]), 50);

      // rst and start in the same IDLE cycle
      @(negedge clk);
      rst0 = 1'b1; start0 = 1'b1;
      @(negedge clk);
      rst0 = 1'b0; start0 = 1'b0;
      check("rststart_busy", int'(busy0), 0);
      check("rststart_strobes", int'(a_read0) + int'(b_read0) + int'(c_write0), 0);
      @(negedge clk);
      check("rststart_busy2", int'(busy0), 0);
      check("rststart_aread2", int'(a_read0), 0);

      // Non-square 2x3x1
      for (int n = 0; n < 6; n++) a_mem1[n] = 8'(n + 1);
      b_mem1[0] = 8'd1; b_mem1[1] = 8'd1; b_mem1[2] = 8'd1;
      bseq[0] = 0; bseq[1] = 1; bseq[2] = 2; bseq[3] = 0; bseq[4] = 1; bseq[5] = 2;
      nb = 0; nw = 0; done_at = -1;
      @(negedge clk);
      start1 = 1'b1;
      for (int t = 1; t <= 9; t++) begin
         @(negedge clk);
         start1 = 1'b0;
         if (b_read1) begin
            if (nb < 6) check("ns_baddr", int'(b_addr1), bseq[nb]);
            nb++;
         end
         if (c_write1) begin
            check("ns_wcyc", t, (nw + 1) * 4);
            check("ns_waddr", int'(c_addr1), nw);
            check("ns_wval", int'(c_val1), (nw == 0) ? 6 : 15);
            nw++;
         end
         if (done1 && done_at < 0) done_at = t;
      end
      check("ns_nreads", nb, 6);
      check("ns_nwrites", nw, 2);
      check("ns_done_cyc", done_at, 9);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/matrix_mult_engine.md
# matrix_mult_engine

Sequencing datapath that consumes two matrix memories (A, B) through their asynchronous read ports and produces C = A × B into a third matrix memory through its synchronous write port. Sits directly downstream of the operand memories and upstream of the result memory. One multiply-accumulate per cycle, one output element written per INNER+1 cycles, single start/done handshake.

## Interface
- ROW, 2, rows of A and C
- INNER, 2, columns of A = rows of B
- COL, 2, columns of B and C
- SIZE, 8, operand element width (unsigned)
- OUT_SIZE, 16, result element / accumulator width (unsigned)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request one full multiply; sampled only in IDLE
- busy  out  1  high from the cycle after start acceptance through the last WRITE cycle
- done  out  1  one-cycle pulse after the last C element is written
- a_read  out  1  read strobe to A memory
- a_read_address  out  6  A element address
- a_data  in  SIZE  A memory read data, valid combinationally in the same cycle as a_read/a_read_address
- b_read  out  1  read strobe to B memory
- b_read_address  out  6  B element address
- b_data  in  SIZE  B memory read data, same-cycle valid
- c_write  out  1  write strobe to C memory
- c_write_address  out  6  C element address
- c_write_value  out  OUT_SIZE  C element value

## Operation
- Storage layout, all row-major: A(i,k) at i*INNER+k; B(k,j) at k*COL+j; C(i,j) at i*COL+j.
- Legal parameters: ROW*INNER, INNER*COL, ROW*COL each ≤ 64; all ≥ 1. No runtime check.
- States: IDLE, MAC, WRITE, DONE.
  - IDLE: busy=0. start=1 → MAC with i=j=k=0.
  - MAC: a_read=b_read=1, addresses from (i,k) and (k,j). acc <= (k==0 ? 0 : acc) + a_data*b_data. k==INNER-1 → WRITE, else k++.
  - WRITE: c_write=1, c_write_address=i*COL+j, c_write_value=acc. k←0; advance j, wrapping to 0 with i++. If (i,j)==(ROW-1,COL-1) → DONE, else → MAC.
  - DONE: done=1, busy=0, one cycle → IDLE.
- Product width 2*SIZE, zero-extended or truncated to OUT_SIZE; accumulation modulo 2^OUT_SIZE, no saturation, no overflow flag.
- Outside MAC: a_read=b_read=0, read addresses 0. Outside WRITE: c_write=0, c_write_address=0, c_write_value=0.
- start while busy or in DONE: ignored, no queuing.
- rst: state→IDLE, counters and acc →0 on the next edge, regardless of state; rst beats a same-cycle start. C elements already written are left as-is; no further writes after the rst edge.

## Timing
- Reset values: busy 0, done 0, a_read 0, b_read 0, c_write 0, all addresses 0, c_write_value 0.
- Cycle 0: start high in IDLE. Cycle 1: first MAC. Element e (0-based) MAC cycles at 1+e*(INNER+1) .. e*(INNER+1)+INNER, its WRITE at (e+1)*(INNER+1).
- Last WRITE at cycle ROW*COL*(INNER+1); done at ROW*COL*(INNER+1)+1; IDLE, able to accept start, the cycle after.
- Default 2×2×2: 12 busy cycles, done at cycle 13; next start earliest at cycle 14.
- Operand data must be stable in the MAC cycle it is addressed; engine samples on that cycle's rising edge end.

## Test plan
- Defaults, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start one cycle → C writes 19@0 (cycle 3), 22@1 (cycle 6), 43@2 (cycle 9), 50@3 (cycle 12); done pulse exactly cycle 13.
- Overflow: SIZE=8, OUT_SIZE=16, all A/B elements 255 → every C element 64514 (130050 mod 65536).
- Non-square ROW=2, INNER=3, COL=1, A=[[1,2,3],[4,5,6]], B=[[1],[1],[1]] → C writes 6@0 (cycle 4), 15@1 (cycle 8); done cycle 9; b_read_address sequence 0,1,2,0,1,2.
- start held high continuously through a run → exactly one run per IDLE visit; second run begins the cycle after returning to IDLE, results identical.
- rst asserted during the second element's MAC → next cycle IDLE, all strobes 0, only C(0,0) written; new start then produces full correct C.
- rst and start high in the same IDLE cycle → stays IDLE, busy 0, no reads or writes.
